// File: rtl/led_fade_driver.sv
// LED output conditioning: per-channel brightness ramp driven by a shared prescaler
// and a shared PWM counter, producing registered PWM drive and per-channel busy flags.
module led_fade_driver #(
    parameter int NUM_LEDS   = 4,
    parameter int PWM_BITS   = 8,
    parameter int STEP_DIV   = 4096,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_LEDS-1:0] led_req,
    output logic [NUM_LEDS-1:0] led_out,
    output logic [NUM_LEDS-1:0] fade_busy
);

    localparam int                    PRESC_BITS = $clog2(STEP_DIV);
    localparam logic [PWM_BITS-1:0]   LVL_MAX    = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0]   LVL_ONE    = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0]   PWM_LAST   = LVL_MAX - LVL_ONE;
    localparam logic [PRESC_BITS-1:0] PRESC_LAST = PRESC_BITS'(STEP_DIV - 1);
    localparam logic [PRESC_BITS-1:0] PRESC_ONE  = PRESC_BITS'(1);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_UP   = 2'd1,
        ST_ON   = 2'd2,
        ST_DOWN = 2'd3
    } fade_state_e;

    logic [PRESC_BITS-1:0] presc_r;
    logic [PWM_BITS-1:0]   pwm_cnt_r;
    logic                  tick_s;

    assign tick_s = (presc_r == PRESC_LAST);

    // Shared step prescaler and PWM period counter (period is MAX clocks, not 2**PWM_BITS).
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_r   <= '0;
            pwm_cnt_r <= '0;
        end else begin
            presc_r   <= tick_s ? '0 : (presc_r + PRESC_ONE);
            pwm_cnt_r <= (pwm_cnt_r == PWM_LAST) ? '0 : (pwm_cnt_r + LVL_ONE);
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        fade_state_e         state_r;
        fade_state_e         state_nxt_s;
        logic [PWM_BITS-1:0] lvl_r;
        logic [PWM_BITS-1:0] lvl_nxt_s;
        logic                led_bit_r;
        logic                busy_bit_r;

        // Channel ramp FSM: a direction change always wins over a tick, so lvl holds that cycle.
        always_comb begin
            state_nxt_s = state_r;
            lvl_nxt_s   = lvl_r;
            case (state_r)
                ST_OFF: begin
                    if (led_req[i]) begin
                        state_nxt_s = ST_UP;
                    end else begin
                        state_nxt_s = ST_OFF;
                    end
                end
                ST_UP: begin
                    if (!led_req[i]) begin
                        state_nxt_s = ST_DOWN;
                    end else if (tick_s) begin
                        // >= so a reversal that starts UP at MAX still saturates
                        if (lvl_r >= PWM_LAST) begin
                            lvl_nxt_s   = LVL_MAX;
                            state_nxt_s = ST_ON;
                        end else begin
                            lvl_nxt_s   = lvl_r + LVL_ONE;
                        end
                    end else begin
                        lvl_nxt_s = lvl_r;
                    end
                end
                ST_ON: begin
                    if (!led_req[i]) begin
                        state_nxt_s = ST_DOWN;
                    end else begin
                        state_nxt_s = ST_ON;
                    end
                end
                ST_DOWN: begin
                    if (led_req[i]) begin
                        state_nxt_s = ST_UP;
                    end else if (tick_s) begin
                        if (lvl_r <= LVL_ONE) begin
                            lvl_nxt_s   = '0;
                            state_nxt_s = ST_OFF;
                        end else begin
                            lvl_nxt_s   = lvl_r - LVL_ONE;
                        end
                    end else begin
                        lvl_nxt_s = lvl_r;
                    end
                end
                default: begin
                    state_nxt_s = ST_OFF;
                    lvl_nxt_s   = '0;
                end
            endcase
        end

        // Channel state, level and registered pin/busy outputs.
        always_ff @(posedge clk) begin
            if (reset) begin
                state_r    <= ST_OFF;
                lvl_r      <= '0;
                led_bit_r  <= ACTIVE_LOW;
                busy_bit_r <= 1'b0;
            end else begin
                state_r    <= state_nxt_s;
                lvl_r      <= lvl_nxt_s;
                led_bit_r  <= (pwm_cnt_r < lvl_r) ^ ACTIVE_LOW;
                busy_bit_r <= (state_nxt_s == ST_UP) || (state_nxt_s == ST_DOWN);
            end
        end

        assign led_out[i]   = led_bit_r;
        assign fade_busy[i] = busy_bit_r;
    end

endmodule
